// File: rtl/bmc_pkg.sv
// Shared types and helpers for the multi-channel BMC decoder.
// Channel FSM states, edge classes and a constant clog2.
package bmc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN_A,
    RUN_B
  } state_t;

  typedef enum logic [1:0] {
    SHORT,
    LONG,
    INVALID
  } cls_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bmc_channel_rx.sv
// One BMC receive lane: synchroniser, interval timer, decode FSM,
// shifter and a single-word holding slot for the arbiter.
module bmc_channel_rx
  import bmc_pkg::*;
#(
  parameter int BIT_CONSIDERED = 17,
  parameter int TS_W           = 24,
  parameter int HALF_BIT       = 8,
  parameter int TOL            = 3,
  parameter int CNT_W          = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enabled,
  input  logic                      d_in,
  input  logic                      e_in,
  input  logic [TS_W-1:0]           sys_ts,
  input  logic                      grant,
  output logic                      pend,
  output logic [BIT_CONSIDERED-1:0] slot_data,
  output logic [TS_W-1:0]           slot_ts,
  output logic                      err_pulse,
  output logic                      ovf
);

  localparam int BCW = clog2(BIT_CONSIDERED);
  localparam int LIM = 2 * HALF_BIT + TOL;
  localparam logic [CNT_W-1:0] MAXC = '1;

  logic [1:0]                sync;
  logic                      dq;
  logic                      edg;
  logic [CNT_W-1:0]          iv;
  logic [CNT_W:0]            intv;
  logic                      timeout;
  cls_t                      cls;
  state_t                    state_q, state_d;
  logic [BIT_CONSIDERED-1:0] sh_q, sh_d;
  logic [BCW-1:0]            cnt_q, cnt_d;
  logic                      err_d;
  logic                      shift;
  logic                      bit_v;
  logic                      done;

  function automatic cls_t classify(input int x);
    if (x >= HALF_BIT - TOL && x <= HALF_BIT + TOL)
      return SHORT;
    if (x >= 2 * HALF_BIT - TOL && x <= 2 * HALF_BIT + TOL)
      return LONG;
    return INVALID;
  endfunction

  // iv is zero in the cycle after an edge, so the span is iv+1
  assign edg     = sync[1] ^ dq;
  assign intv    = {1'b0, iv} + {{CNT_W{1'b0}}, 1'b1};
  assign cls     = classify(int'(intv));
  assign timeout = int'(iv) > LIM;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    shift   = 1'b0;
    bit_v   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enabled && !e_in) state_d = SYNC;
      end
      SYNC: begin
        if (edg) state_d = RUN_A;
      end
      RUN_A: begin
        if (edg) begin
          unique case (cls)
            LONG:    shift = 1'b1;
            SHORT:   state_d = RUN_B;
            default: begin
              err_d   = 1'b1;
              state_d = SYNC;
            end
          endcase
        end else if (timeout) begin
          err_d   = cnt_q != '0;
          state_d = SYNC;
        end
      end
      RUN_B: begin
        if (edg && cls == SHORT) begin
          shift   = 1'b1;
          bit_v   = 1'b1;
          state_d = RUN_A;
        end else if (edg || timeout) begin
          err_d   = 1'b1;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
    if (shift) begin
      sh_d = {sh_q[BIT_CONSIDERED-2:0], bit_v};
      if (cnt_q == BCW'(BIT_CONSIDERED - 1)) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + BCW'(1);
      end
    end
    // Losing carrier or enable drops the partial word without an error
    if (!enabled || e_in) begin
      state_d = IDLE;
      err_d   = 1'b0;
      done    = 1'b0;
    end
    if (state_d == IDLE || state_d == SYNC) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      dq        <= 1'b0;
      iv        <= '0;
      state_q   <= SYNC;
      sh_q      <= '0;
      cnt_q     <= '0;
      err_pulse <= 1'b0;
      pend      <= 1'b0;
      slot_data <= '0;
      slot_ts   <= '0;
      ovf       <= 1'b0;
    end else begin
      sync      <= {sync[0], d_in};
      dq        <= sync[1];
      iv        <= edg ? '0 : (iv == MAXC ? iv : iv + CNT_W'(1));
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      err_pulse <= err_d;
      if (!enabled) begin
        pend <= 1'b0;
        ovf  <= 1'b0;
      end else if (done && pend && !grant) begin
        ovf <= 1'b1;
      end else if (done) begin
        pend      <= 1'b1;
        slot_data <= sh_d;
        slot_ts   <= sys_ts;
      end else if (grant) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bmc_decoder_mc.sv
// N_CH BMC lanes merged onto one valid/ready output by a
// round-robin arbiter feeding a single output register.
module bmc_decoder_mc
  import bmc_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int BIT_CONSIDERED = 17,
  parameter int TS_W           = 24,
  parameter int HALF_BIT       = 8,
  parameter int TOL            = 3,
  parameter int CNT_W          = 6,
  localparam int CH_W          = clog2(N_CH)
) (
  input  logic                      clk_96MHz,
  input  logic                      reset_n,
  input  logic                      enabled,
  input  logic [N_CH-1:0]           d_in,
  input  logic [N_CH-1:0]           e_in,
  input  logic [TS_W-1:0]           sys_ts,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_ch,
  output logic [BIT_CONSIDERED-1:0] out_data,
  output logic [TS_W-1:0]           out_ts,
  output logic [N_CH-1:0]           err_pulse,
  output logic [N_CH-1:0]           ovf
);

  logic [N_CH-1:0]                      pend;
  logic [N_CH-1:0]                      grant;
  logic [N_CH-1:0][BIT_CONSIDERED-1:0]  slot_data;
  logic [N_CH-1:0][TS_W-1:0]            slot_ts;
  logic [CH_W-1:0]                      rr;
  logic [CH_W-1:0]                      gnt_idx;
  logic                                 gnt_any;
  logic                                 take;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    bmc_channel_rx #(
      .BIT_CONSIDERED(BIT_CONSIDERED),
      .TS_W          (TS_W),
      .HALF_BIT      (HALF_BIT),
      .TOL           (TOL),
      .CNT_W         (CNT_W)
    ) u_rx (
      .clk      (clk_96MHz),
      .rst_n    (reset_n),
      .enabled  (enabled),
      .d_in     (d_in[g]),
      .e_in     (e_in[g]),
      .sys_ts   (sys_ts),
      .grant    (grant[g]),
      .pend     (pend[g]),
      .slot_data(slot_data[g]),
      .slot_ts  (slot_ts[g]),
      .err_pulse(err_pulse[g]),
      .ovf      (ovf[g])
    );
  end

  assign take = enabled && (!out_valid || out_ready);

  always_comb begin
    int k;
    k       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int i = 0; i < N_CH; i++) begin
      k = (int'(rr) + i) % N_CH;
      if (!gnt_any && pend[k]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(k);
      end
    end
    if (take && gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ts    <= '0;
      rr        <= '0;
    end else if (!enabled) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_ch   <= gnt_idx;
        out_data <= slot_data[gnt_idx];
        out_ts   <= slot_ts[gnt_idx];
        rr       <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bmc_decoder_mc.sv
// Directed bench for bmc_decoder_mc: BMC streams driven per channel,
// expected words queued at the last edge and popped on handshake.
module tb_bmc_decoder_mc;

  localparam int N_CH = 4;
  localparam int BC   = 17;
  localparam int TS_W = 24;
  localparam logic [BC-1:0] W1 = 17'h17274;
  localparam logic [BC-1:0] W2 = 17'h0A5A5;
  localparam logic [BC-1:0] W3 = 17'h1C3F0;

  typedef struct packed {
    logic [1:0]      ch;
    logic [BC-1:0]   data;
    logic [TS_W-1:0] ts;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            enabled = 1'b1;
  logic            out_ready = 1'b1;
  logic [N_CH-1:0] d_in = '0;
  logic [N_CH-1:0] e_in = '0;
  logic [TS_W-1:0] sys_ts;
  logic            out_valid;
  logic [1:0]      out_ch;
  logic [BC-1:0]   out_data;
  logic [TS_W-1:0] out_ts;
  logic [N_CH-1:0] err_pulse;
  logic [N_CH-1:0] ovf;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   words = 0;
  int   errs[N_CH] = '{default: 0};
  int   hs_q[$];
  exp_t sb[$];
  int   ivq[$];
  int   si = 0;
  int   li = 0;
  int   sh_tab[5] = '{5, 11, 7, 9, 11};
  int   lg_tab[4] = '{13, 19, 15, 17};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sys_ts = cyc[TS_W-1:0];

  bmc_decoder_mc dut (
    .clk_96MHz(clk),
    .reset_n  (reset_n),
    .enabled  (enabled),
    .d_in     (d_in),
    .e_in     (e_in),
    .sys_ts   (sys_ts),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_data (out_data),
    .out_ts   (out_ts),
    .err_pulse(err_pulse),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N_CH; i++)
      if (err_pulse[i]) errs[i]++;
    if (reset_n && out_valid && out_ready) begin
      n_chk++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL unexpected_word: got %h expected none", out_data);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_ch", 64'(out_ch), 64'(e.ch));
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_ts", 64'(out_ts), 64'(e.ts));
      end
      words++;
      hs_q.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First nb bits of w, MSB first; jit picks off-nominal intervals
  task automatic mk_word(input logic [BC-1:0] w, input int nb,
                         input bit jit);
    ivq.delete();
    for (int b = BC - 1; b >= BC - nb; b--) begin
      if (w[b]) begin
        ivq.push_back(jit ? sh_tab[si % 5] : 8);
        si++;
        ivq.push_back(jit ? sh_tab[si % 5] : 8);
        si++;
      end else begin
        ivq.push_back(jit ? lg_tab[li % 4] : 16);
        li++;
      end
    end
  endtask

  task automatic play(input logic [N_CH-1:0] mask, output int t_last);
    step(1);
    d_in ^= mask;
    foreach (ivq[i]) begin
      step(ivq[i]);
      d_in ^= mask;
    end
    t_last = cyc;
  endtask

  // Two synchroniser flops put the detection cycle's sys_ts at t+2
  task automatic push(input int ch, input logic [BC-1:0] w, input int t);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = w;
    e.ts   = TS_W'(t + 2);
    sb.push_back(e);
  endtask

  initial begin
    int t;
    int gap;
    #1 reset_n = 1'b0;
    step(3);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_ts", 64'(out_ts), 0);
    chk("rst_err", 64'(err_pulse), 0);
    chk("rst_ovf", 64'(ovf), 0);
    reset_n = 1'b1;
    step(5);

    mk_word(W1, BC, 1'b0);
    play(4'b0001, t);
    push(0, W1, t);
    step(40);
    chk("t1_words", 64'(words), 1);
    chk("t1_err", 64'(errs[0]), 0);

    mk_word(W1, BC, 1'b1);
    play(4'b0001, t);
    push(0, W1, t);
    step(40);
    chk("t2_words", 64'(words), 2);
    chk("t2_err", 64'(errs[0]), 0);

    ivq = '{8, 8, 16, 8, 8, 12};
    play(4'b0001, t);
    step(40);
    chk("t3_err", 64'(errs[0]), 1);
    chk("t3_no_word", 64'(words), 2);
    mk_word(W2, BC, 1'b0);
    play(4'b0001, t);
    push(0, W2, t);
    step(40);
    chk("t3_words", 64'(words), 3);
    chk("t3_err_after", 64'(errs[0]), 1);

    mk_word(W1, 9, 1'b0);
    play(4'b0001, t);
    step(4);
    e_in[0] = 1'b1;
    step(30);
    chk("t4_no_word", 64'(words), 3);
    chk("t4_no_err", 64'(errs[0]), 1);
    e_in[0] = 1'b0;
    step(3);
    mk_word(W3, BC, 1'b0);
    play(4'b0001, t);
    push(0, W3, t);
    step(40);
    chk("t4_words", 64'(words), 4);
    chk("t4_err", 64'(errs[0]), 1);

    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(30);
    hs_q.delete();
    mk_word(W2, BC, 1'b0);
    play(4'b0110, t);
    push(1, W2, t);
    push(2, W2, t);
    step(40);
    chk("t5_words", 64'(words), 6);
    chk("t5_hs_n", 64'(hs_q.size()), 2);
    gap = (hs_q.size() >= 2) ? hs_q[1] - hs_q[0] : -1;
    chk("t5_gap", 64'(gap), 1);
    chk("sb_drained", 64'(sb.size()), 0);

    out_ready = 1'b0;
    mk_word(W1, BC, 1'b0);
    play(4'b0001, t);
    step(40);
    chk("t6_valid", 64'(out_valid), 1);
    chk("t6_data1", 64'(out_data), 64'(W1));
    chk("t6_ts1", 64'(out_ts), 64'(TS_W'(t + 2)));
    mk_word(W2, BC, 1'b0);
    play(4'b0001, t);
    step(40);
    chk("t6_hold2", 64'(out_data), 64'(W1));
    chk("t6_no_ovf", 64'(ovf), 0);
    mk_word(W3, BC, 1'b0);
    play(4'b0001, t);
    step(40);
    chk("t6_ovf", 64'(ovf), 1);
    chk("t6_hold3", 64'(out_data), 64'(W1));
    chk("t6_ch", 64'(out_ch), 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 0);
    chk("t6_async_ovf", 64'(ovf), 0);
    step(2);
    reset_n = 1'b1;
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
